// File: rtl/enc_8_3_pri_q_pkg.sv
// enc_pkg: shared constants and types for the registered 8-to-3 priority
// encoder (enc_8_3_pri_q) and its combinational selector (pri_enc_8_3).
//   N_REQ    number of request lines
//   IDX_W    width of the binary code
//   ostate_e output-stage state: EMPTY (nothing offered) / OFFER (y valid)
//   onehot() binary index -> one-hot request vector
package enc_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      EMPTY = 1'b0,
      OFFER = 1'b1
   } ostate_e;

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      return N_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/pri_enc_8_3.sv
// pri_enc_8_3: combinational 8-to-3 priority encoder.
//   MSB_FIRST  1: highest set index wins; 0: lowest set index wins
//   vec  [7:0] input vector
//   idx  [2:0] index of the winning bit (0 when vec is zero)
//   any        vec has at least one bit set
module pri_enc_8_3
   import enc_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic [N_REQ-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      idx = '0;
      any = |vec;
      // Scan so that the winning bit is the last one visited.
      if (MSB_FIRST) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) idx = IDX_W'(i);
         end
      end else begin
         for (int i = N_REQ-1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/enc_8_3_pri_q.sv
// enc_8_3_pri_q: registered 8-to-3 priority encoder with request queueing.
// Request lines are captured into a pending register; the top-priority
// pending request is offered as a binary code on a valid/ready output and
// retired when the consumer accepts it.
//   MSB_FIRST  1: req[7] highest priority; 0: req[0] highest priority
//   EDGE_MODE  0: level capture; 1: rising-edge capture
//   clk, rst_n  clock (rising edge), async active-low reset
//   en          capture enable (draining continues when low)
//   req [7:0]   request lines
//   clr_all     synchronous flush of pending requests and the offer
//   y_valid/y_ready/y[2:0]  offered code handshake
//   pending [7:0]  captured requests not yet offered
//   drop        one-cycle pulse: edge capture merged into a queued bit
module enc_8_3_pri_q
   import enc_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1,
   parameter bit EDGE_MODE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   input  logic             clr_all,
   output logic             y_valid,
   input  logic             y_ready,
   output logic [IDX_W-1:0] y,
   output logic [N_REQ-1:0] pending,
   output logic             drop
);

   ostate_e          state_q, state_d;
   logic [IDX_W-1:0] y_q, y_d;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [N_REQ-1:0] req_d_q;
   logic             drop_q, drop_d;

   logic [N_REQ-1:0] inflight;
   logic [N_REQ-1:0] cap;
   logic [N_REQ-1:0] pend_in;
   logic [IDX_W-1:0] sel_idx;
   logic             sel_any;
   logic             load;

   assign y_valid  = (state_q == OFFER);
   assign inflight = y_valid ? onehot(y_q) : '0;

   always_comb begin
      cap = '0;
      if (en) begin
         if (EDGE_MODE) cap = req & ~req_d_q;
         else           cap = req & ~pending_q & ~inflight;
      end
   end

   // An edge on the code currently offered is absorbed by that offer, so the
   // source is served once per queued event, not once per edge.
   assign pend_in = pending_q | (cap & ~inflight);
   assign load    = (state_q == EMPTY) || (y_valid && y_ready);

   pri_enc_8_3 #(.MSB_FIRST(MSB_FIRST)) u_sel (
      .vec (pend_in),
      .idx (sel_idx),
      .any (sel_any)
   );

   always_comb begin
      state_d   = state_q;
      y_d       = y_q;
      pending_d = pend_in;
      drop_d    = EDGE_MODE && ((cap & (pending_q | inflight)) != '0);
      if (clr_all) begin
         state_d   = EMPTY;
         pending_d = '0;
         drop_d    = 1'b0;
      end else if (load) begin
         if (sel_any) begin
            state_d   = OFFER;
            y_d       = sel_idx;
            pending_d = pend_in & ~onehot(sel_idx);
         end else begin
            // y keeps its last code while the stage is empty.
            state_d = EMPTY;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         y_q       <= '0;
         pending_q <= '0;
         drop_q    <= 1'b0;
         req_d_q   <= '0;
      end else begin
         state_q   <= state_d;
         y_q       <= y_d;
         pending_q <= pending_d;
         drop_q    <= drop_d;
         // Edge history tracks req even when disabled or flushing.
         req_d_q   <= req;
      end
   end

   assign y       = y_q;
   assign pending = pending_q;
   assign drop    = drop_q;

endmodule

// File: tb/tb_enc_8_3_pri_q.sv
// Directed bench: three encoder variants share one stimulus stream.
//   a: MSB_FIRST=1 EDGE_MODE=1   b: MSB_FIRST=0 EDGE_MODE=1
//   c: MSB_FIRST=1 EDGE_MODE=0
module tb_enc_8_3_pri_q;

   logic       clk = 1'b0;
   logic       rst_n, en, clr_all, y_ready;
   logic [7:0] req;

   logic       v_a, v_b, v_c, d_a, d_b, d_c;
   logic [2:0] y_a, y_b, y_c;
   logic [7:0] p_a, p_b, p_c;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   enc_8_3_pri_q #(.MSB_FIRST(1'b1), .EDGE_MODE(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .clr_all(clr_all),
      .y_valid(v_a), .y_ready(y_ready), .y(y_a), .pending(p_a), .drop(d_a));
   enc_8_3_pri_q #(.MSB_FIRST(1'b0), .EDGE_MODE(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .clr_all(clr_all),
      .y_valid(v_b), .y_ready(y_ready), .y(y_b), .pending(p_b), .drop(d_b));
   enc_8_3_pri_q #(.MSB_FIRST(1'b1), .EDGE_MODE(1'b0)) dut_c (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .clr_all(clr_all),
      .y_valid(v_c), .y_ready(y_ready), .y(y_c), .pending(p_c), .drop(d_c));

   // Expected sequences for req=8'h89 captured in one cycle.
   logic [2:0] pr_ya [3] = '{3'd7, 3'd3, 3'd0};
   logic [7:0] pr_pa [3] = '{8'h09, 8'h01, 8'h00};
   logic [2:0] pr_yb [3] = '{3'd0, 3'd3, 3'd7};
   logic [7:0] pr_pb [3] = '{8'h88, 8'h80, 8'h00};
   // Level re-service: ready pattern and expected valid on variant c.
   logic       lv_rdy [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   logic       lv_vld [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; clr_all = 1'b0; y_ready = 1'b0; req = 8'h00;
      #12;
      n_vec++;
      if ({v_a, y_a, p_a, d_a, v_b, y_b, p_b, d_b, v_c, y_c, p_c, d_c} !== '0) begin
         n_err++;
         $display("FAIL reset: a=%b/%0d/%h/%b b=%b/%0d/%h/%b c=%b/%0d/%h/%b want all 0",
                  v_a, y_a, p_a, d_a, v_b, y_b, p_b, d_b, v_c, y_c, p_c, d_c);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      n_vec++;
      if ({v_a, p_a, v_b, p_b, v_c, p_c} !== '0) begin
         n_err++;
         $display("FAIL reset_idle: v=%b%b%b p=%h %h %h want idle", v_a, v_b, v_c, p_a, p_b, p_c);
      end
   endtask

   task automatic test_single();
      y_ready = 1'b1; req = 8'h20;
      step();
      req = 8'h00;
      n_vec++;
      if ({v_a, y_a, p_a} !== {1'b1, 3'd5, 8'h00} || {v_b, y_b, p_b} !== {1'b1, 3'd5, 8'h00} ||
          {v_c, y_c, p_c} !== {1'b1, 3'd5, 8'h00}) begin
         n_err++;
         $display("FAIL single_offer: y=%0d/%0d/%0d v=%b%b%b want y=5 v=111", y_a, y_b, y_c, v_a, v_b, v_c);
      end
      step();
      n_vec++;
      if ({v_a, p_a, v_b, p_b, v_c, p_c} !== '0) begin
         n_err++;
         $display("FAIL single_retire: v=%b%b%b p=%h %h %h want empty", v_a, v_b, v_c, p_a, p_b, p_c);
      end
   endtask

   task automatic test_priority();
      y_ready = 1'b1; req = 8'h89;
      step();
      req = 8'h00;
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if ({v_a, y_a, p_a} !== {1'b1, pr_ya[i], pr_pa[i]} ||
             {v_c, y_c, p_c} !== {1'b1, pr_ya[i], pr_pa[i]}) begin
            n_err++;
            $display("FAIL prio_msb[%0d]: a=%b/%0d/%h c=%b/%0d/%h want 1/%0d/%h",
                     i, v_a, y_a, p_a, v_c, y_c, p_c, pr_ya[i], pr_pa[i]);
         end
         n_vec++;
         if ({v_b, y_b, p_b} !== {1'b1, pr_yb[i], pr_pb[i]}) begin
            n_err++;
            $display("FAIL prio_lsb[%0d]: b=%b/%0d/%h want 1/%0d/%h", i, v_b, y_b, p_b, pr_yb[i], pr_pb[i]);
         end
         step();
      end
      n_vec++;
      if ({v_a, v_b, v_c} !== 3'b000) begin
         n_err++;
         $display("FAIL prio_drain: v=%b%b%b want 000", v_a, v_b, v_c);
      end
   endtask

   task automatic test_backpressure();
      y_ready = 1'b0; req = 8'h06;
      step();
      req = 8'h00;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if ({v_a, y_a, p_a} !== {1'b1, 3'd2, 8'h02} || {v_c, y_c, p_c} !== {1'b1, 3'd2, 8'h02} ||
             {v_b, y_b, p_b} !== {1'b1, 3'd1, 8'h04}) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: a=%b/%0d/%h b=%b/%0d/%h c=%b/%0d/%h",
                     i, v_a, y_a, p_a, v_b, y_b, p_b, v_c, y_c, p_c);
         end
         step();
      end
      y_ready = 1'b1;
      step();
      n_vec++;
      if ({v_a, y_a, p_a} !== {1'b1, 3'd1, 8'h00} || {v_c, y_c, p_c} !== {1'b1, 3'd1, 8'h00} ||
          {v_b, y_b, p_b} !== {1'b1, 3'd2, 8'h00}) begin
         n_err++;
         $display("FAIL bp_release: y=%0d/%0d/%0d p=%h %h %h want y=1/2/1 p=0", y_a, y_b, y_c, p_a, p_b, p_c);
      end
      step();
      n_vec++;
      if ({v_a, v_b, v_c} !== 3'b000) begin
         n_err++;
         $display("FAIL bp_drain: v=%b%b%b want 000", v_a, v_b, v_c);
      end
   endtask

   task automatic test_edge_drop();
      int cnt_a, cnt_b, cnt_c;
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      y_ready = 1'b0; req = 8'h10;
      step();
      req = 8'h00;
      n_vec++;
      if ({v_a, y_a, d_a, v_b, y_b, d_b, v_c, y_c, d_c} !== {1'b1, 3'd4, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 3'd4, 1'b0}) begin
         n_err++;
         $display("FAIL drop_first: v=%b%b%b y=%0d/%0d/%0d d=%b%b%b", v_a, v_b, v_c, y_a, y_b, y_c, d_a, d_b, d_c);
      end
      step();
      req = 8'h10;
      step();
      req = 8'h00;
      n_vec++;
      if ({d_a, d_b, d_c} !== 3'b110 || {p_a, p_b, p_c} !== '0) begin
         n_err++;
         $display("FAIL drop_pulse: d=%b%b%b want 110, p=%h %h %h want 0", d_a, d_b, d_c, p_a, p_b, p_c);
      end
      step();
      n_vec++;
      if ({d_a, d_b, d_c} !== 3'b000) begin
         n_err++;
         $display("FAIL drop_one_cycle: d=%b%b%b want 000", d_a, d_b, d_c);
      end
      y_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (v_a && y_a == 3'd4) cnt_a++;
         if (v_b && y_b == 3'd4) cnt_b++;
         if (v_c && y_c == 3'd4) cnt_c++;
         step();
      end
      n_vec++;
      if (cnt_a != 1 || cnt_b != 1 || cnt_c != 1) begin
         n_err++;
         $display("FAIL drop_single_delivery: count=%0d/%0d/%0d want 1/1/1", cnt_a, cnt_b, cnt_c);
      end
   endtask

   task automatic test_level();
      y_ready = 1'b0; req = 8'h04;
      step();
      n_vec++;
      if ({v_c, y_c, p_c} !== {1'b1, 3'd2, 8'h00}) begin
         n_err++;
         $display("FAIL level_first: c=%b/%0d/%h want 1/2/00", v_c, y_c, p_c);
      end
      for (int i = 0; i < 4; i++) begin
         y_ready = lv_rdy[i];
         step();
         n_vec++;
         if (v_c !== lv_vld[i] || (lv_vld[i] && y_c !== 3'd2) || p_c[2] !== 1'b0 || d_c !== 1'b0) begin
            n_err++;
            $display("FAIL level_reserve[%0d]: c v=%b y=%0d p=%h d=%b want v=%b y=2 p[2]=0 d=0",
                     i, v_c, y_c, p_c, d_c, lv_vld[i]);
         end
      end
      req = 8'h00; y_ready = 1'b1;
      step();
      step();
      n_vec++;
      if ({v_a, v_b, v_c} !== 3'b000 || {p_a, p_b, p_c} !== '0) begin
         n_err++;
         $display("FAIL level_drain: v=%b%b%b p=%h %h %h", v_a, v_b, v_c, p_a, p_b, p_c);
      end
   endtask

   task automatic test_flush();
      y_ready = 1'b0; req = 8'h01;
      step();
      req = 8'hF0;
      step();
      n_vec++;
      if ({v_a, y_a, p_a} !== {1'b1, 3'd0, 8'hF0} || {v_b, y_b, p_b} !== {1'b1, 3'd0, 8'hF0} ||
          {v_c, y_c, p_c} !== {1'b1, 3'd0, 8'hF0}) begin
         n_err++;
         $display("FAIL flush_setup: a=%b/%0d/%h b=%b/%0d/%h c=%b/%0d/%h want 1/0/f0",
                  v_a, y_a, p_a, v_b, y_b, p_b, v_c, y_c, p_c);
      end
      req = 8'h01; clr_all = 1'b1;
      step();
      clr_all = 1'b0; req = 8'h00;
      n_vec++;
      if ({v_a, v_b, v_c} !== 3'b000 || {p_a, p_b, p_c} !== '0) begin
         n_err++;
         $display("FAIL flush_clear: v=%b%b%b p=%h %h %h want empty", v_a, v_b, v_c, p_a, p_b, p_c);
      end
      y_ready = 1'b1;
      step();
      n_vec++;
      if ({v_a, v_b, v_c} !== 3'b000 || {p_a, p_b, p_c} !== '0) begin
         n_err++;
         $display("FAIL flush_discard: v=%b%b%b p=%h %h %h want empty", v_a, v_b, v_c, p_a, p_b, p_c);
      end
   endtask

   task automatic test_enable_reset();
      en = 1'b0; req = 8'hFF; y_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_vec++;
         if ({v_a, v_b, v_c} !== 3'b000 || {p_a, p_b, p_c} !== '0) begin
            n_err++;
            $display("FAIL en_block[%0d]: v=%b%b%b p=%h %h %h want empty", i, v_a, v_b, v_c, p_a, p_b, p_c);
         end
      end
      en = 1'b1;
      step();
      n_vec++;
      if ({v_a, v_b} !== 2'b00 || {v_c, y_c, p_c} !== {1'b1, 3'd7, 8'h7F}) begin
         n_err++;
         $display("FAIL en_resume: v=%b%b c=%b/%0d/%h want 00 and 1/7/7f", v_a, v_b, v_c, y_c, p_c);
      end
      y_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({v_c, y_c, p_c} !== '0) begin
         n_err++;
         $display("FAIL async_reset: c=%b/%0d/%h want 0/0/00", v_c, y_c, p_c);
      end
      @(negedge clk);
      rst_n = 1'b1; req = 8'h00;
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_backpressure();
      test_edge_drop();
      test_level();
      test_flush();
      test_enable_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/enc_8_3_pri_q.md
Name: enc_8_3_pri_q

Overview:
- Registered 8-to-3 priority encoder with request queueing; the inverse of the team's 3-to-8 decoder.
- Eight request lines are captured into a pending register. The highest-priority pending request is offered as a 3-bit code on a valid/ready output and is retired on acceptance.
- Sits between per-source request lines (interrupt/event sources) and a single consumer that later decodes the code back to one-hot.

Parameters:
- MSB_FIRST, 1: 1 = req[7] has highest priority; 0 = req[0] has highest priority.
- EDGE_MODE, 0: 0 = level capture; 1 = rising-edge capture.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  capture enable; 0 blocks new captures only.
- req  input  8  request lines.
- clr_all  input  1  synchronous flush of pending and offer.
- y_valid  output  1  offered code is valid.
- y_ready  input  1  consumer accepts the code.
- y  output  3  binary index of the offered request.
- pending  output  8  captured requests not yet offered (registered).
- drop  output  1  one-cycle pulse: edge-mode capture merged into an already-queued bit.

Behaviour:
- Reset (async, rst_n=0): pending=0, y_valid=0, y=0, drop=0, req_d=0 (edge history).
- Capture vector cap:
  - EDGE_MODE=0: cap = req & ~pending & ~inflight.
  - EDGE_MODE=1: cap = req & ~req_d.
  - Both modes: cap is gated by en. inflight = one-hot(y) when y_valid, else 0.
  - req_d is updated every cycle regardless of en, so an edge that occurs while en=0 is lost.
- Merge: pend_in = pending | cap.
- drop: in EDGE_MODE=1, drop=1 for one cycle if (cap & (pending | inflight)) != 0. The capture is merged and not counted twice. drop is always 0 in level mode.
- Output stage has two states:
  - EMPTY: y_valid=0.
  - OFFER: y_valid=1.
- Load condition: load = (state==EMPTY) or (y_valid and y_ready).
- On load:
  - If pend_in != 0: y <= priority-encode(pend_in); go to or stay in OFFER; pending <= pend_in with the selected bit cleared.
  - Else: go to EMPTY; pending <= pend_in; y holds its last value.
- When not loading: pending <= pend_in; y and y_valid are held stable. While y_valid=1 and y_ready=0, y must not change.
- Latency: with the stage EMPTY, a request sampled at edge k appears as y_valid=1 with its code immediately after edge k (1 cycle).
- Throughput: with y_ready held at 1, one code is delivered per cycle, back-to-back, with no bubble.
- Simultaneous acceptance and capture: the accepted bit is retired, and new captures compete in the same cycle's selection.
- Level mode with a held request: the request is not re-captured while pending or in flight. It is re-captured in the cycle after its acceptance, so the source is re-served until req drops.
- clr_all=1 (synchronous, highest priority over capture, load and acceptance): pending <= 0, y_valid <= 0, drop <= 0. Same-cycle captures are discarded. req_d still updates.
- en=0: no new captures; pending requests continue to drain normally.
- Priority: MSB_FIRST=1 selects the highest set index; MSB_FIRST=0 selects the lowest set index.

Decomposition:
- Package enc_pkg:
  - N_REQ=8, IDX_W=3.
  - Two-state output-state enum: EMPTY, OFFER.
- One combinational sub-module pri_enc_8_3:
  - Inputs: vec[7:0], parameter MSB_FIRST.
  - Outputs: idx[2:0], any.
  - Instantiated once, on pend_in.
- All registers live in enc_8_3_pri_q.

Test Plan:
- Reset then single request:
  - Stimulus: rst_n low with req=8'h00; release; req=8'h20 for 1 cycle; y_ready=1.
  - Response: after the capturing edge, y_valid=1 and y=3'd5 for one cycle; then y_valid=0 and pending=0.
- Priority ordering:
  - Stimulus: MSB_FIRST=1, EDGE_MODE=1; req=8'h89 in one cycle; y_ready=1.
  - Response: y=7, then 3, then 0 on consecutive cycles; pending=0x09, then 0x01, then 0x00.
  - Repeat with MSB_FIRST=0: y=0, then 3, then 7.
- Backpressure hold:
  - Stimulus: req=8'h06 (edge); y_ready=0 for 4 cycles.
  - Response: y=2 is held stable with y_valid=1 and pending=0x02 throughout; raising y_ready gives y=1 on the next cycle.
- Edge-mode drop:
  - Stimulus: bit 4 pulses twice while y=4 is held with y_ready=0.
  - Response: drop=1 for exactly one cycle on the second pulse; only one y=4 is delivered after release.
- Level re-service:
  - Stimulus: EDGE_MODE=0; req[2] held high; y_ready toggles 1,0,1.
  - Response: y=2 is offered repeatedly; pending[2] never sets while y=2 is in flight; drop stays 0.
- Flush and enable:
  - Stimulus: pending=0xF0 with an offer outstanding; clr_all=1 together with req=8'h01.
  - Response: next cycle pending=0 and y_valid=0, and bit 0 is not captured.
  - Stimulus: en=0 with req=8'hFF.
  - Response: no captures.
  - Stimulus: rst_n asserted mid-offer.
  - Response: y_valid drops immediately (asynchronously).
